// File: rtl/instr_fetch.sv
// instr_fetch: edge-triggered instruction fetch unit with a 16x8 program store.
// A rising edge on load_ir fetches store[pc] into instruction, advances pc and
// pulses fetch_valid for one cycle. Fetching HALT_WORD (or running off the end
// of the store) parks the unit in HALT until restart.
//
// Handshake: fetch_valid is a one-cycle qualifier with no back-pressure; the
// CPU must capture instruction in the cycle fetch_valid is high, because the
// next accepted fetch overwrites it.
//
// Configuration macro: IFETCH_PC_WRAP_EN
//   defined   - a fetch at pc=15 wraps pc to 0 and fetching continues.
//   undefined - a fetch at pc=15 delivers the word, holds pc=15 and halts.
module instr_fetch #(
    parameter logic [3:0] RESET_PC  = 4'h0,
    parameter logic [7:0] HALT_WORD = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_ir,
    input  logic       restart,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] instruction,
    output logic [3:0] pc,
    output logic       fetch_valid,
    output logic       halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t     state;
    logic       load_ir_q;
    logic       halt_pending;
    logic [7:0] store [16];

    logic       fetch_event;
    logic       take_fetch;
    logic [7:0] fetch_word;
    logic [3:0] pc_next;
    logic       end_of_store;

    // Rising edge of the level-type load_ir strobe.
    assign fetch_event = load_ir && !load_ir_q;

    // Read happens against the pre-write store contents, so a same-cycle
    // program write to the fetched address returns the old word.
    assign fetch_word = store[pc];

    // Restart outranks a fetch; a pending halt outranks a back-to-back fetch.
    assign take_fetch = fetch_event && !restart &&
                        ((state == IDLE) || ((state == FETCH) && !halt_pending));

`ifdef IFETCH_PC_WRAP_EN
    assign pc_next      = pc + 4'd1;
    assign end_of_store = 1'b0;
`else
    assign pc_next      = (pc == 4'hF) ? pc : pc + 4'd1;
    assign end_of_store = (pc == 4'hF);
`endif

    // Program store: written from the program port in any state, never reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            store[prog_addr] <= prog_data;
        end
    end

    // Fetch FSM with registered instruction/pc/fetch_valid/halted outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            instruction  <= 8'h00;
            fetch_valid  <= 1'b0;
            halted       <= 1'b0;
            load_ir_q    <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            load_ir_q   <= load_ir;
            fetch_valid <= 1'b0;
            if (restart) begin
                state        <= IDLE;
                pc           <= RESET_PC;
                halted       <= 1'b0;
                halt_pending <= 1'b0;
            end else if (take_fetch) begin
                state        <= FETCH;
                instruction  <= fetch_word;
                pc           <= pc_next;
                fetch_valid  <= 1'b1;
                halt_pending <= (fetch_word == HALT_WORD) || end_of_store;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    FETCH: begin
                        if (halt_pending) begin
                            state        <= HALT;
                            halted       <= 1'b1;
                            halt_pending <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HALT: begin
                        state <= HALT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 4'h0, PC value loaded on reset and on restart.
REQ-002 SHALL have parameter HALT_WORD, default 8'h00, instruction byte that stops fetching.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_ir  input  1  CPU load-IR strobe, level signal, fetch triggered on its rising edge.
REQ-006 SHALL have port restart  input  1  synchronous pulse: leave HALT and reload PC.
REQ-007 SHALL have port prog_we  input  1  program-port write enable.
REQ-008 SHALL have port prog_addr  input  4  program-port write address.
REQ-009 SHALL have port prog_data  input  8  program-port write data.
REQ-010 SHALL have port instruction  output  8  registered instruction presented to the CPU.
REQ-011 SHALL have port pc  output  4  address of the next word to fetch.
REQ-012 SHALL have port fetch_valid  output  1  one-cycle pulse: instruction updated this cycle.
REQ-013 SHALL have port halted  output  1  high while in HALT.

Function
REQ-014 SHALL hold a 16 x 8 instruction store; prog_we=1 writes prog_data to prog_addr at the clock edge, in any state.
REQ-015 SHALL register load_ir into load_ir_q every cycle; a fetch event is load_ir=1 and load_ir_q=0 sampled at an edge.
REQ-016 SHALL implement states IDLE, FETCH, HALT: IDLE->FETCH on a fetch event; FETCH->IDLE after one cycle; FETCH->HALT when the fetched word equals HALT_WORD; HALT->IDLE on restart.
REQ-017 On a fetch event SHALL, at that same edge, load instruction<=store[pc], advance pc by 1, and drive fetch_valid=1 for exactly the following cycle (one-edge latency).
REQ-018 SHALL deliver the HALT_WORD itself on instruction with fetch_valid, then assert halted from the next cycle; pc advances past it.
REQ-019 In HALT SHALL ignore fetch events: instruction, pc, and fetch_valid=0 held.
REQ-020 restart SHALL set pc=RESET_PC, clear halted, and enter IDLE; restart coincident with a fetch event SHALL take priority and perform no fetch that cycle.
REQ-021 A write to the address being fetched in the same cycle SHALL return the old (pre-write) data on instruction.
REQ-022 A load_ir held high for many cycles SHALL produce exactly one fetch; a new fetch requires load_ir to return low for at least one sampled cycle.
REQ-023 A fetch event arriving while in FETCH (load_ir toggled at clock rate) SHALL be accepted; back-to-back fetches at every second cycle SHALL each deliver one word.
REQ-024 pc arithmetic SHALL be 4-bit unsigned; wrap behaviour per REQ-028/029.

Reset
REQ-025 Reset low SHALL immediately force: state=IDLE, pc=RESET_PC, instruction=8'h00, fetch_valid=0, halted=0, load_ir_q=0.
REQ-026 Reset SHALL NOT clear the instruction store; contents survive reset.
REQ-027 Reset asserted mid-FETCH SHALL abort the pulse: fetch_valid=0 immediately, no pc advance completed.

Configuration
REQ-028 With macro IFETCH_PC_WRAP_EN defined, a fetch at pc=15 SHALL deliver store[15] and set pc=0, continuing normally.
REQ-029 Without IFETCH_PC_WRAP_EN, a fetch at pc=15 SHALL deliver store[15], leave pc=15, and enter HALT (halted=1) regardless of word value.

Verification
REQ-030 Program store[0..3]=D1,51,D2,11, store[4]=00; reset; five load_ir pulses -> instruction D1,51,D2,11,00, each with one fetch_valid pulse; halted=1 after the fifth; pc=5.
REQ-031 In HALT, pulse load_ir twice -> instruction stays 00, no fetch_valid, pc=5; pulse restart -> halted=0, pc=0; next load_ir -> instruction D1.
REQ-032 Hold load_ir high 10 cycles after reset -> exactly one fetch_valid, pc=1.
REQ-033 Fill store with 8'hA0+i, fetch 16 times then once more -> with IFETCH_PC_WRAP_EN: 17th gives A0, pc=1; without: halted=1 after 16th, pc=15, 17th ignored.
REQ-034 Write store[2]=77 in the same cycle as fetch at pc=2 holding 55 -> instruction=55; after restart and re-fetch of address 2 -> 77.
REQ-035 Assert reset during the fetch_valid cycle at pc=3 -> fetch_valid=0, instruction=00, pc=0 immediately; store contents unchanged on re-fetch.
